// File: rtl/sdram_arb_pkg.sv
// Shared types and default constants for the SDRAM slot arbiter.
// Contents:
//   state_e         sequencer states RST -> GUARD -> INIT -> IDLE <-> SLOT
//   port_sel_e      which requester owns the current slot
//   *_DEF           default slot geometry and address width
//   CTRL_INIT_COUNT number of slots the controller needs to finish power-up
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    RST,
    GUARD,
    INIT,
    IDLE,
    SLOT
  } state_e;

  typedef enum logic [1:0] {
    DL,
    GFX,
    CPU
  } port_sel_e;

  localparam int SLOT_LEN_DEF    = 8;
  localparam int CAPTURE_PH_DEF  = 6;
  localparam int AW_DEF          = 25;
  localparam int CTRL_INIT_COUNT = 'h14C08;

endpackage

// File: rtl/sdram_arbiter_rr_arb2.sv
// Requester selection for the SDRAM slot arbiter.
// The download port always wins. Graphics and CPU share the remaining slots
// round-robin, using a one-bit record of which of them was granted last.
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   en_i           a slot may be granted this clock
//   dl_req_i       download request (absolute priority)
//   gfx_req_i      graphics read request
//   cpu_req_i      CPU read request
//   valid_o        at least one request is pending
//   sel_o          selected requester (meaningful while valid_o is high)
module rr_arb2
  import sdram_arb_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      en_i,
  input  logic      dl_req_i,
  input  logic      gfx_req_i,
  input  logic      cpu_req_i,
  output logic      valid_o,
  output port_sel_e sel_o
);

  // 1 = graphics won the last read grant, 0 = CPU did (reset value).
  logic last_gfx_q, last_gfx_d;

  always_comb begin
    valid_o    = dl_req_i | gfx_req_i | cpu_req_i;
    sel_o      = DL;
    last_gfx_d = last_gfx_q;
    if (dl_req_i) begin
      sel_o = DL;
    end else if (gfx_req_i && cpu_req_i) begin
      sel_o = last_gfx_q ? CPU : GFX;
    end else if (gfx_req_i) begin
      sel_o = GFX;
    end else begin
      sel_o = CPU;
    end
    // Download grants leave the read fairness state untouched.
    if (en_i && valid_o && !dl_req_i) begin
      last_gfx_d = (sel_o == GFX);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_gfx_q <= 1'b0;
    end else begin
      last_gfx_q <= last_gfx_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Sequencer and slot arbiter in front of the 8-bit-write / 16-bit-read SDRAM
// controller. After reset it pulses sd_init, waits one slot length so an
// interrupted controller cycle can finish, then runs INIT_SLOTS dummy read
// slots at address 0 to clock the controller's power-up counter. Afterwards
// it grants one access slot at a time to dl (write), gfx or cpu (reads).
// Ports:
//   clk, reset_n           clock and synchronous active-low reset
//   sd_init                init strobe to the controller
//   sd_addr, sd_di         address / write byte, held for the whole slot
//   sd_rd, sd_we           request strobes, high at phases 0 and 1
//   sd_rdata               16-bit read data from the controller
//   dl_req/addr/data/ack   download write port
//   gfx_req/addr/dout/ack  graphics read port
//   cpu_req/addr/dout/ack  CPU read port
//   busy                   high during power-up and while a slot runs
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int SLOT_LEN   = SLOT_LEN_DEF,
  parameter int CAPTURE_PH = CAPTURE_PH_DEF,
  parameter int INIT_SLOTS = CTRL_INIT_COUNT,
  parameter int AW         = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          sd_init,
  output logic [AW-1:0] sd_addr,
  output logic          sd_rd,
  output logic          sd_we,
  output logic [7:0]    sd_di,
  input  logic [15:0]   sd_rdata,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  output logic          dl_ack,
  input  logic          gfx_req,
  input  logic [AW-1:0] gfx_addr,
  output logic [15:0]   gfx_dout,
  output logic          gfx_ack,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic [15:0]   cpu_dout,
  output logic          cpu_ack,
  output logic          busy
);

  // Phase needs one extra code: INIT uses phase SLOT_LEN as the gap clock
  // that gives dummy slots the same period as back-to-back real slots.
  localparam int PH_W  = $clog2(SLOT_LEN + 1);
  localparam int CNT_W = (INIT_SLOTS > 1) ? $clog2(INIT_SLOTS) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SLOT_LEN - 1);
  localparam logic [PH_W-1:0]  PH_GAP   = PH_W'(SLOT_LEN);
  localparam logic [PH_W-1:0]  PH_CAP   = PH_W'(CAPTURE_PH);
  localparam logic [PH_W-1:0]  PH_DLACK = PH_W'(SLOT_LEN - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_SLOTS - 1);

  state_e          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  port_sel_e       sel_q, sel_d;
  logic            sd_init_q, sd_init_d;
  logic            sd_rd_q, sd_rd_d;
  logic            sd_we_q, sd_we_d;
  logic [AW-1:0]   sd_addr_q, sd_addr_d;
  logic [7:0]      sd_di_q, sd_di_d;
  logic [15:0]     gfx_dout_q, gfx_dout_d;
  logic [15:0]     cpu_dout_q, cpu_dout_d;
  logic            dl_ack_q, dl_ack_d;
  logic            gfx_ack_q, gfx_ack_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            busy_q, busy_d;

  logic            arb_valid;
  port_sel_e       arb_sel;

  // Reads are word accesses; the byte-select bit is dropped.
  logic            unused_addr_lsb;
  assign unused_addr_lsb = gfx_addr[0] ^ cpu_addr[0];

  rr_arb2 u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_i      (state_q == IDLE),
    .dl_req_i  (dl_req),
    .gfx_req_i (gfx_req),
    .cpu_req_i (cpu_req),
    .valid_o   (arb_valid),
    .sel_o     (arb_sel)
  );

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    sd_init_d  = 1'b0;
    sd_rd_d    = 1'b0;
    sd_we_d    = 1'b0;
    sd_addr_d  = sd_addr_q;
    sd_di_d    = sd_di_q;
    gfx_dout_d = gfx_dout_q;
    cpu_dout_d = cpu_dout_q;
    dl_ack_d   = 1'b0;
    gfx_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    case (state_q)
      RST: begin
        state_d = GUARD;
        ph_d    = '0;
      end
      GUARD: begin
        if (ph_q == PH_LAST) begin
          state_d   = INIT;
          ph_d      = '0;
          cnt_d     = '0;
          sd_rd_d   = 1'b1;
          sd_addr_d = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      INIT: begin
        if ((ph_q == PH_LAST) && (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          ph_d    = '0;
        end else if (ph_q == PH_GAP) begin
          ph_d    = '0;
          cnt_d   = cnt_q + 1'b1;
          sd_rd_d = 1'b1;
        end else begin
          ph_d    = ph_q + 1'b1;
          sd_rd_d = (ph_q == '0);
        end
      end
      IDLE: begin
        if (arb_valid) begin
          state_d = SLOT;
          ph_d    = '0;
          sel_d   = arb_sel;
          case (arb_sel)
            DL: begin
              sd_we_d   = 1'b1;
              sd_addr_d = dl_addr;
              sd_di_d   = dl_data;
            end
            GFX: begin
              sd_rd_d   = 1'b1;
              sd_addr_d = {gfx_addr[AW-1:1], 1'b0};
            end
            default: begin
              sd_rd_d   = 1'b1;
              sd_addr_d = {cpu_addr[AW-1:1], 1'b0};
            end
          endcase
        end
      end
      SLOT: begin
        ph_d    = ph_q + 1'b1;
        sd_we_d = (ph_q == '0) && (sel_q == DL);
        sd_rd_d = (ph_q == '0) && (sel_q != DL);
        // Acks are registered, so they are decided one phase early.
        if (sel_q == DL) begin
          dl_ack_d = (ph_q == PH_DLACK);
        end else if (ph_q == PH_CAP) begin
          if (sel_q == GFX) begin
            gfx_dout_d = sd_rdata;
            gfx_ack_d  = 1'b1;
          end else begin
            cpu_dout_d = sd_rdata;
            cpu_ack_d  = 1'b1;
          end
        end
        if (ph_q == PH_LAST) begin
          state_d = IDLE;
          ph_d    = '0;
        end
      end
      default: state_d = RST;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= RST;
      ph_q       <= '0;
      cnt_q      <= '0;
      sel_q      <= DL;
      sd_init_q  <= 1'b1;
      sd_rd_q    <= 1'b0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_di_q    <= '0;
      gfx_dout_q <= '0;
      cpu_dout_q <= '0;
      dl_ack_q   <= 1'b0;
      gfx_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      sd_init_q  <= sd_init_d;
      sd_rd_q    <= sd_rd_d;
      sd_we_q    <= sd_we_d;
      sd_addr_q  <= sd_addr_d;
      sd_di_q    <= sd_di_d;
      gfx_dout_q <= gfx_dout_d;
      cpu_dout_q <= cpu_dout_d;
      dl_ack_q   <= dl_ack_d;
      gfx_ack_q  <= gfx_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign sd_init  = sd_init_q;
  assign sd_rd    = sd_rd_q;
  assign sd_we    = sd_we_q;
  assign sd_addr  = sd_addr_q;
  assign sd_di    = sd_di_q;
  assign gfx_dout = gfx_dout_q;
  assign cpu_dout = cpu_dout_q;
  assign dl_ack   = dl_ack_q;
  assign gfx_ack  = gfx_ack_q;
  assign cpu_ack  = cpu_ack_q;
  assign busy     = busy_q;

endmodule
